// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - 1-wire serial frame receiver: start, 7 data LSB first, even parity, stop
module serial_receiver #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       serial_in,
    output logic [6:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    sr;
    logic          at_mid;
    logic          at_last;

    assign at_mid  = (cnt == MID);
    assign at_last = (cnt == LAST);

    // cnt holds the offset within the current bit cell of the edge being evaluated
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            sr         <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state     <= state_next;
            valid     <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE)
                cnt <= (state_next == START) ? CW'(1) : '0;
            else if (state_next != state || at_last)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (state == IDLE)
                bit_cnt <= '0;
            else if (state == DATA && at_last)
                bit_cnt <= bit_cnt + 3'd1;

            if (state == DATA && at_mid)
                sr[bit_cnt] <= serial_in;

            if (state == STOP && at_mid) begin
                data_out <= sr[6:0];
                if (serial_in) begin
                    valid      <= 1'b1;
                    parity_err <= ^sr;
                end else begin
                    frame_err  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // With one clock per bit the start sample is also its mid-cell check
                if (!serial_in)
                    state_next = (CLKS_PER_BIT == 1) ? DATA : START;
            end
            START: begin
                if (at_mid && serial_in)
                    state_next = IDLE;
                else if (at_last)
                    state_next = DATA;
            end
            DATA: begin
                if (at_last && bit_cnt == 3'd7)
                    state_next = STOP;
            end
            STOP: begin
                if (at_mid)
                    state_next = serial_in ? IDLE : WAIT_HI;
            end
            WAIT_HI: begin
                if (serial_in)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end
endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - directed bench for serial_receiver at 1 and 4 clocks per bit
module tb_serial_receiver;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       ser1 = 1'b1;
    logic       ser4 = 1'b1;
    logic [6:0] d1, d4;
    logic       v1, pe1, fe1, b1;
    logic       v4, pe4, fe4, b4;

    int checks = 0;
    int errors = 0;
    int v1_cnt = 0;
    int v4_cnt = 0;
    int n;

    serial_receiver #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rstn(rstn), .serial_in(ser1), .data_out(d1), .valid(v1),
        .parity_err(pe1), .frame_err(fe1), .busy(b1)
    );

    serial_receiver #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rstn(rstn), .serial_in(ser4), .data_out(d4), .valid(v4),
        .parity_err(pe4), .frame_err(fe4), .busy(b4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (v1) v1_cnt <= v1_cnt + 1;
        if (v4) v4_cnt <= v4_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [6:0] d, input logic par, input logic stp);
        ser1 = 1'b0;
        tick(1);
        for (int i = 0; i < 7; i++) begin
            ser1 = d[i];
            tick(1);
        end
        ser1 = par;
        tick(1);
        check("pre_stop_valid_low", v1, 1'b0);
        ser1 = stp;
        tick(1);
    endtask

    task automatic send4(input logic [6:0] d, input logic par);
        ser4 = 1'b0;
        tick(4);
        for (int i = 0; i < 7; i++) begin
            ser4 = d[i];
            tick(4);
        end
        ser4 = par;
        tick(4);
        ser4 = 1'b1;
        tick(3);
    endtask

    initial begin
        rstn = 1'b0;
        ser1 = 1'b0;
        ser4 = 1'b0;
        tick(2);
        check("rst_data", d1, 7'h00);
        check("rst_valid", v1, 1'b0);
        check("rst_perr", pe1, 1'b0);
        check("rst_ferr", fe1, 1'b0);
        check("rst_busy", b1, 1'b0);
        check("rst_busy4", b4, 1'b0);
        ser1 = 1'b1;
        ser4 = 1'b1;
        rstn = 1'b1;
        tick(3);
        check("idle_busy", b1, 1'b0);

        n = v1_cnt;
        send1(7'h55, 1'b0, 1'b1);
        check("good_valid", v1, 1'b1);
        check("good_data", d1, 7'h55);
        check("good_perr", pe1, 1'b0);
        check("good_ferr", fe1, 1'b0);
        tick(1);
        check("good_valid_pulse", v1, 1'b0);
        check("good_data_hold", d1, 7'h55);
        check("good_count", v1_cnt, n + 1);

        send1(7'h07, 1'b0, 1'b1);
        check("par_valid", v1, 1'b1);
        check("par_data", d1, 7'h07);
        check("par_perr", pe1, 1'b1);
        tick(1);
        check("par_perr_hold", pe1, 1'b1);

        n = v1_cnt;
        send1(7'h01, 1'b1, 1'b0);
        check("fe_pulse", fe1, 1'b1);
        check("fe_valid", v1, 1'b0);
        check("fe_data", d1, 7'h01);
        check("fe_perr_hold", pe1, 1'b1);
        tick(5);
        check("fe_busy_low_line", b1, 1'b1);
        check("fe_pulse_once", fe1, 1'b0);
        ser1 = 1'b1;
        tick(1);
        check("fe_busy_released", b1, 1'b0);
        tick(2);
        check("fe_no_frame", v1_cnt, n);

        n = v1_cnt;
        send1(7'h12, 1'b0, 1'b1);
        check("b2b_valid_a", v1, 1'b1);
        check("b2b_data_a", d1, 7'h12);
        check("b2b_perr_a", pe1, 1'b0);
        send1(7'h6C, 1'b0, 1'b1);
        check("b2b_valid_b", v1, 1'b1);
        check("b2b_data_b", d1, 7'h6C);
        ser1 = 1'b1;
        tick(1);
        check("b2b_count", v1_cnt, n + 2);

        n = v4_cnt;
        ser4 = 1'b0;
        tick(1);
        check("glitch_busy", b4, 1'b1);
        ser4 = 1'b1;
        tick(2);
        check("glitch_idle", b4, 1'b0);
        tick(4);
        check("glitch_no_frame", v4_cnt, n);

        send4(7'h3A, 1'b0);
        check("slow_valid", v4, 1'b1);
        check("slow_data", d4, 7'h3A);
        check("slow_perr", pe4, 1'b0);
        tick(1);
        check("slow_valid_pulse", v4, 1'b0);

        n = v4_cnt;
        ser4 = 1'b0;
        tick(4);
        ser4 = 1'b1;
        tick(4);
        ser4 = 1'b0;
        tick(2);
        rstn = 1'b0;
        tick(1);
        check("midrst_busy", b4, 1'b0);
        check("midrst_data", d4, 7'h00);
        rstn = 1'b1;
        ser4 = 1'b1;
        tick(40);
        check("midrst_no_frame", v4_cnt, n);
        check("midrst_idle", b4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
